// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Brief   : Shared FSM encoding and requester indices for mem_arbiter.
// Revision: 1.0
// ============================================================================
package mem_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter_if
// Brief   : Requester and memory-side signals of the two-requester arbiter.
// Revision: 1.0
// ============================================================================
interface mem_arbiter_if #(
  parameter int n = 16
);

  logic         Req0, Req1;
  logic         W0, W1;
  logic [n-1:0] ADDR0, ADDR1;
  logic [n-1:0] DOUT0, DOUT1;
  logic         Lock0, Lock1;
  logic         Gnt0, Gnt1;
  logic         Ack0, Ack1;
  logic [n-1:0] RData;
  logic [n-1:0] MemADDR;
  logic [n-1:0] MemDOUT;
  logic         MemW;
  logic [n-1:0] MemDIN;

  // master: requesters plus the memory; slave: the arbiter
  modport master (
    output Req0, Req1, W0, W1, ADDR0, ADDR1, DOUT0, DOUT1, Lock0, Lock1, MemDIN,
    input  Gnt0, Gnt1, Ack0, Ack1, RData, MemADDR, MemDOUT, MemW
  );

  modport slave (
    input  Req0, Req1, W0, W1, ADDR0, ADDR1, DOUT0, DOUT1, Lock0, Lock1, MemDIN,
    output Gnt0, Gnt1, Ack0, Ack1, RData, MemADDR, MemDOUT, MemW
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick2
// Brief   : Combinational two-way round-robin picker; ties go to !last.
// Revision: 1.0
// ============================================================================
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = req[1] & (~req[0] | ~last);
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin arbiter/sequencer for one single-port sync memory,
//           with a bounded grant lock for back-to-back sequences.
// Revision: 1.0
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int n        = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic         Clock,
  input  logic         Resetn,
  mem_arbiter_if.slave bus
);

  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX - 1);

  logic [1:0]   state;
  logic         owner;
  logic         last;
  logic [3:0]   lock_cnt;

  logic         req_own;
  logic         lock_own;
  logic         w_own;
  logic [n-1:0] addr_own;
  logic [n-1:0] dout_own;
  logic         lock_hit;
  logic [1:0]   cand;
  logic         pick_valid;
  logic         pick_winner;
  logic         arb_valid;
  logic         arb_winner;

  assign req_own  = (owner == REQ_LDR) ? bus.Req1  : bus.Req0;
  assign lock_own = (owner == REQ_LDR) ? bus.Lock1 : bus.Lock0;
  assign w_own    = (owner == REQ_LDR) ? bus.W1    : bus.W0;
  assign addr_own = (owner == REQ_LDR) ? bus.ADDR1 : bus.ADDR0;
  assign dout_own = (owner == REQ_LDR) ? bus.DOUT1 : bus.DOUT0;

  assign lock_hit = (state == RESP) && lock_own && req_own && (lock_cnt < LOCK_LIMIT);

  // The requester being acked still holds Req for the finishing transaction
  always_comb begin
    cand = {bus.Req1, bus.Req0};
    if (state == RESP) begin
      cand[owner] = 1'b0;
    end
  end

  rr_pick2 u_pick (
    .req    (cand),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  assign arb_valid  = lock_hit | pick_valid;
  assign arb_winner = lock_hit ? owner : pick_winner;

  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state    <= IDLE;
      owner    <= REQ_CPU;
      last     <= REQ_LDR;
      lock_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state <= ISSUE;
            owner <= arb_winner;
            last  <= arb_winner;
          end
        end
        ISSUE: begin
          state <= RESP;
        end
        RESP: begin
          lock_cnt <= lock_hit ? (lock_cnt + 4'd1) : 4'd0;
          if (arb_valid) begin
            state <= ISSUE;
            owner <= arb_winner;
            last  <= arb_winner;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write enable is gated by reset so an aborted write never reaches memory
  assign bus.MemW    = w_own & (state == ISSUE) & ~Resetn;
  assign bus.MemADDR = (state != IDLE) ? addr_own : '0;
  assign bus.MemDOUT = (state != IDLE) ? dout_own : '0;
  assign bus.RData   = (state == RESP) ? bus.MemDIN : '0;

  assign bus.Gnt0 = (state != IDLE) && (owner == REQ_CPU);
  assign bus.Gnt1 = (state != IDLE) && (owner == REQ_LDR);
  assign bus.Ack0 = (state == RESP) && (owner == REQ_CPU);
  assign bus.Ack1 = (state == RESP) && (owner == REQ_LDR);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Scoreboard bench for mem_arbiter with a behavioural memory model.
// Revision: 1.0
// ============================================================================
module tb_mem_arbiter;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.n(N)) bus ();

  mem_arbiter #(.n(N), .LOCK_MAX(4)) dut (
    .Clock  (clk),
    .Resetn (rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic         w;
    logic [N-1:0] data;
  } exp_t;

  exp_t         exp_q0[$];
  exp_t         exp_q1[$];
  int           ack_log[$];
  int           ack_cyc[$];
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;

  logic [N-1:0] mem     [0:255];
  logic [N-1:0] ref_mem [0:255];
  bit           mem_clr = 1'b0;
  bit           bd_we   = 1'b0;
  logic [7:0]   bd_addr = 8'h00;
  logic [N-1:0] bd_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: write at the edge ending ISSUE, read data one cycle later
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bus.MemW) begin
      mem[bus.MemADDR[7:0]] <= bus.MemDOUT;
    end
    bus.MemDIN <= mem[bus.MemADDR[7:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic get_ack(input int r);
    return (r == 0) ? bus.Ack0 : bus.Ack1;
  endfunction

  function automatic logic get_gnt(input int r);
    return (r == 0) ? bus.Gnt0 : bus.Gnt1;
  endfunction

  function automatic int log_at(input int i);
    return (i < ack_log.size()) ? ack_log[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ack_cyc.size()) ? ack_cyc[i] : -1;
  endfunction

  task automatic drive(input int r, input logic req, input logic w,
                       input logic [N-1:0] a, input logic [N-1:0] d, input logic lk);
    if (r == 0) begin
      bus.Req0 = req; bus.W0 = w; bus.ADDR0 = a; bus.DOUT0 = d; bus.Lock0 = lk;
    end else begin
      bus.Req1 = req; bus.W1 = w; bus.ADDR1 = a; bus.DOUT1 = d; bus.Lock1 = lk;
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [N-1:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic reset_dut(input bit clr);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    mem_clr = clr;
    @(posedge clk); #1;
    mem_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    if (clr) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    ack_log.delete();
    ack_cyc.delete();
  endtask

  // One transaction: expected response is queued at issue time from the reference memory
  task automatic do_txn(input int r, input logic w, input logic [7:0] a,
                        input logic [N-1:0] d, input logic lk, input bit keep);
    exp_t e;
    bit   got;
    got    = 1'b0;
    e.w    = w;
    e.data = w ? '0 : ref_mem[a];
    if (w) ref_mem[a] = d;
    if (r == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    drive(r, 1'b1, w, {8'h00, a}, d, lk);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (get_ack(r)) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: req%0d got no Ack in 20 cycles, required one", r);
    end
    @(posedge clk); #1;
    if (!keep || !got) drive(r, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic rand_requester(input int r, input int n, input logic [7:0] base);
    int   gap;
    int   nxt;
    bit   keep;
    logic w;
    gap = int'($urandom_range(0, 2));
    for (int k = 0; k < n; k++) begin
      repeat (gap) begin @(posedge clk); #1; end
      nxt  = (k == n - 1) ? 1 : int'($urandom_range(0, 3));
      keep = (k < n - 1) && (nxt == 0);
      w    = ($urandom_range(0, 1) == 1);
      do_txn(r, w, base + 8'($urandom_range(0, 15)), 16'($urandom),
             keep && ($urandom_range(0, 2) == 0), keep);
      gap = nxt;
    end
  endtask

  // Monitor: pops the scoreboard whenever an Ack is presented
  initial begin
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.Ack0 && bus.Ack1) chk("dual_ack", 32'({bus.Ack1, bus.Ack0}), 32'h1);
        for (int r = 0; r < 2; r++) begin
          if (get_ack(r)) begin
            ack_log.push_back(r);
            ack_cyc.push_back(cyc);
            chk("gnt_with_ack", 32'(get_gnt(r)), 32'h1);
            have = (r == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            chk("ack_expected", 32'(have), 32'h1);
            if (have) begin
              e = (r == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              if (!e.w) chk("rdata", 32'(bus.RData), 32'(e.data));
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, required the bench to complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int n0;
    int lock_exp[6];
    lock_exp = '{0, 0, 0, 0, 1, 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    // Reset state
    reset_dut(1'b1);
    @(negedge clk);
    chk("rst_ctrl", 32'({bus.Gnt1, bus.Gnt0, bus.Ack1, bus.Ack0, bus.MemW}), 32'h0);
    chk("rst_memaddr", 32'(bus.MemADDR), 32'h0);
    chk("rst_memdout", 32'(bus.MemDOUT), 32'h0);
    chk("rst_rdata", 32'(bus.RData), 32'h0);
    @(posedge clk); #1;

    // Single read by requester 0
    bd_write(8'h10, 16'hBEEF);
    t0 = cyc;
    fork
      do_txn(0, 1'b0, 8'h10, '0, 1'b0, 1'b0);
      begin
        @(negedge clk);
        chk("rd_gnt0_t0", 32'(bus.Gnt0), 32'h0);
        @(negedge clk);
        chk("rd_gnt0_t1", 32'(bus.Gnt0), 32'h1);
        chk("rd_memaddr_t1", 32'(bus.MemADDR), 32'h10);
        chk("rd_memw_t1", 32'(bus.MemW), 32'h0);
        @(negedge clk);
        chk("rd_ack0_t2", 32'({bus.Gnt0, bus.Ack0}), 32'h3);
        chk("rd_rdata_t2", 32'(bus.RData), 32'hBEEF);
        chk("rd_memw_t2", 32'(bus.MemW), 32'h0);
      end
    join
    chk("rd_ack_cycle", 32'(cyc_at(0)), 32'(t0 + 2));
    @(negedge clk);
    chk("rd_idle_after", 32'({bus.Gnt1, bus.Gnt0}), 32'h0);
    @(posedge clk); #1;

    // Simultaneous writes after reset: requester 0 first
    reset_dut(1'b0);
    t0 = cyc;
    fork
      do_txn(0, 1'b1, 8'h05, 16'h1111, 1'b0, 1'b0);
      do_txn(1, 1'b1, 8'h06, 16'h2222, 1'b0, 1'b0);
    join
    chk("wr_first", 32'(log_at(0)), 32'h0);
    chk("wr_first_cyc", 32'(cyc_at(0)), 32'(t0 + 2));
    chk("wr_second", 32'(log_at(1)), 32'h1);
    chk("wr_second_cyc", 32'(cyc_at(1)), 32'(t0 + 4));
    chk("wr_mem5", 32'(mem[5]), 32'h1111);
    chk("wr_mem6", 32'(mem[6]), 32'h2222);

    // Round-robin fairness: both held for 8 transactions
    reset_dut(1'b1);
    for (int k = 0; k < 8; k++) bd_write(8'(8'h20 + k), 16'(16'hA000 + k));
    t0 = cyc;
    fork
      begin for (int k = 0; k < 4; k++) do_txn(0, 1'b0, 8'(8'h20 + k), '0, 1'b0, k < 3); end
      begin for (int k = 0; k < 4; k++) do_txn(1, 1'b0, 8'(8'h24 + k), '0, 1'b0, k < 3); end
    join
    chk("rr_count", 32'(ack_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_order", 32'(log_at(i)), 32'(i % 2));
      chk("rr_cycle", 32'(cyc_at(i)), 32'(t0 + 2 + 2 * i));
    end

    // Lock bound with LOCK_MAX=4
    reset_dut(1'b1);
    t0 = cyc;
    fork
      begin for (int k = 0; k < 5; k++) do_txn(0, 1'b0, 8'(8'h20 + k), '0, k < 4, k < 4); end
      do_txn(1, 1'b0, 8'h28, '0, 1'b0, 1'b0);
    join
    chk("lock_count", 32'(ack_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("lock_order", 32'(log_at(i)), 32'(lock_exp[i]));
      chk("lock_cycle", 32'(cyc_at(i)), 32'(t0 + 2 + 2 * i));
    end

    // Reset during ISSUE of a write
    reset_dut(1'b1);
    bd_write(8'h09, 16'h1234);
    drive(1, 1'b1, 1'b1, 16'h0009, 16'hDEAD, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_gnt1", 32'(bus.Gnt1), 32'h1);
    chk("rstmid_memw", 32'(bus.MemW), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    chk("rstmid_ctrl", 32'({bus.Gnt1, bus.Gnt0, bus.Ack1, bus.Ack0, bus.MemW}), 32'h0);
    chk("rstmid_bus", 32'({bus.MemADDR, bus.RData}), 32'h0);
    @(posedge clk); #1;
    chk("rstmid_mem9", 32'(mem[9]), 32'h1234);
    chk("rstmid_no_ack", 32'(ack_log.size()), 32'h0);

    // Idle gap after a single read by requester 1
    bd_write(8'h30, 16'h5A5A);
    n0 = ack_log.size();
    t0 = cyc;
    do_txn(1, 1'b0, 8'h30, '0, 1'b0, 1'b0);
    chk("gap_ack_cycle", 32'(cyc_at(n0)), 32'(t0 + 2));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_gnt", 32'({bus.Gnt1, bus.Gnt0}), 32'h0);
      chk("gap_memaddr", 32'(bus.MemADDR), 32'h0);
      chk("gap_rdata", 32'(bus.RData), 32'h0);
      @(posedge clk); #1;
    end

    // Randomized traffic on disjoint address windows
    reset_dut(1'b1);
    fork
      rand_requester(0, 40, 8'h40);
      rand_requester(1, 40, 8'h50);
    join
    n0 = 0;
    foreach (ack_log[i]) if (ack_log[i] == 0) n0++;
    chk("rand_ack0_count", 32'(n0), 32'd40);
    chk("rand_ack1_count", 32'(ack_log.size() - n0), 32'd40);
    chk("rand_queues_empty", 32'(exp_q0.size() + exp_q1.size()), 32'h0);
    for (int i = 0; i < 32; i++) chk("rand_mem", 32'(mem[8'h40 + i]), 32'(ref_mem[8'h40 + i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single-port synchronous data memory behind the processor's ADDR/DOUT/W/DataFromMemory path. It multiplexes requester 0 (processor core) and requester 1 (loader/DMA port) onto one memory port. Arbitration is round-robin, with an optional bounded lock for back-to-back sequences such as read-modify-write. Each transaction is a fixed two-cycle ISSUE/RESP sequence closed by a one-cycle Ack pulse.

## Interface
Parameters:
- n, 16, data and address width
- LOCK_MAX, 4, maximum consecutive transactions one owner may hold by Lock (range 1..15)

Ports:
- Clock  in  1  single clock; all state changes on the rising edge
- Resetn  in  1  synchronous, active-high reset (name kept from codebase; 1 = reset)
- Req0 / Req1  in  1  transaction request; held high until the matching Ack
- W0 / W1  in  1  1 = write, 0 = read; stable while Req is high
- ADDR0 / ADDR1  in  n  word address; stable while Req is high
- DOUT0 / DOUT1  in  n  write data; stable while Req is high
- Lock0 / Lock1  in  1  request to keep the grant for the requester's next transaction
- Gnt0 / Gnt1  out  1  requester owns the port (ISSUE and RESP)
- Ack0 / Ack1  out  1  one-cycle completion pulse, high in RESP
- RData  out  n  read data, valid while an Ack is high (don't-care on writes)
- MemADDR  out  n  memory address
- MemDOUT  out  n  memory write data
- MemW  out  1  memory write enable
- MemDIN  in  n  memory read data, valid in the cycle after the address is sampled

## Operation
- FSM states: IDLE, ISSUE, RESP. Registers: state, owner (1 bit), last (1 bit, last served), lock_cnt (4 bits).
- Arbitration runs in IDLE and RESP.
  - Candidate set is {r | Req_r}, excluding in RESP the requester being acked this cycle unless its lock applies.
  - If exactly one candidate, it wins.
  - If both are candidates, the requester != last wins.
- Lock: in RESP, if Lock_owner && Req_owner && lock_cnt < LOCK_MAX-1, the owner re-wins regardless of the other requester, and lock_cnt increments. Otherwise lock_cnt clears to 0 and normal arbitration applies.
- IDLE → ISSUE on a winner: owner updates, last updates to the winner. With no candidate, stay in IDLE.
- ISSUE → RESP always.
- RESP → ISSUE on a winner; otherwise RESP → IDLE.
- Memory side is combinational from owner and state:
  - MemADDR = ADDR_owner and MemDOUT = DOUT_owner in ISSUE and RESP; 0 in IDLE.
  - MemW = W_owner & (state==ISSUE) & !Resetn.
- RData = MemDIN in RESP; 0 otherwise.
- Gnt_r = (state != IDLE) & (owner==r). Ack_r = (state==RESP) & (owner==r).

## Timing
- Reset values: state IDLE, owner 0, last 1 (requester 0 wins the first tie), lock_cnt 0. All outputs read 0.
- Latency from Req to Ack:
  - Req rises in cycle t while IDLE → ISSUE in t+1, Ack in t+2.
  - Back-to-back service: one transaction per 2 cycles; the Memory port is never idle while requests are pending.
- Write: memory samples MemW/MemADDR/MemDOUT at the edge ending ISSUE.
- Read: MemDIN is returned in RESP and passed to RData in the same cycle.
- Requester must drop Req, or present its next transaction, in the cycle after Ack. Req still high after Ack is treated as a new request.
- Req dropped during ISSUE (protocol violation): the transaction still completes and Ack still pulses.
- Lock asserted by a non-owner has no effect.
- Reset mid-transaction: MemW is forced 0 in the reset cycle, so no write occurs at the reset edge. The transaction aborts with no Ack, and the FSM is in IDLE next cycle.

## Structure
- Shared package `mem_arb_pkg`: state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) and the requester index constants REQ_CPU=0, REQ_LDR=1.
- One natural sub-module, `rr_pick2`: combinational two-way round-robin picker with inputs req[1:0] and last, outputs valid and winner. Everything else is flat in mem_arbiter.

## Test plan
- Reset then single read: Req0=1, W0=0, ADDR0=16'h0010, memory[16'h0010]=16'hBEEF → Gnt0 in t+1 and t+2, Ack0 with RData=16'hBEEF in t+2, MemW=0 throughout.
- Simultaneous writes: Req0 and Req1 rise together with ADDR0=5, DOUT0=16'h1111, ADDR1=6, DOUT1=16'h2222 → requester 0 is served first (Ack0 at t+2), requester 1 next (Ack1 at t+4), and memory holds 16'h1111 and 16'h2222.
- Round-robin fairness: Req0 and Req1 held high continuously for 8 transactions → Acks alternate 0,1,0,1… with exactly 4 each.
- Lock bound: Lock0=1 with Req0 and Req1 both held, LOCK_MAX=4 → four consecutive Ack0 pulses, then Ack1, then Ack0 again.
- Reset during ISSUE of a write (W1=1, ADDR1=9, DOUT1=16'hDEAD), with Resetn=1 in that cycle → memory[9] unchanged, no Ack1, state IDLE and all outputs 0 on the next cycle.
- Idle gap: one read by requester 1, then no requests for 3 cycles → FSM returns to IDLE after RESP, and MemADDR and RData stay 0 during the gap.
